// File: rtl/autocat_tuner.sv
// autocat_tuner: per-LRU-position sampled hit counting over an epoch, then a
// cumulative-coverage scan that publishes the smallest covering way mask.
module autocat_tuner #(
    parameter int NUM_WAY       = 16,
    parameter int COUNTER_WIDTH = 32,
    parameter int SET_ADDR_LEN  = 64,
    parameter int EPOCH_POWER   = 20,
    parameter int SAMPLE_SHIFT  = 0,
    parameter int COVER_NUM     = 15,
    parameter int COVER_SHIFT   = 4,
    parameter int MIN_WAYS      = 1
) (
    input  logic                             clk_in,
    input  logic                             reset_with_request_limit,
    input  logic                             cfg_enable,
    input  logic [SET_ADDR_LEN-1:0]          set_address,
    input  logic                             access_valid,
    input  logic [NUM_WAY-1:0]               hit_vec,
    output logic [NUM_WAY*COUNTER_WIDTH-1:0] cat_counter_flatted,
    output logic [NUM_WAY-1:0]               suggested_waymask,
    output logic [$clog2(NUM_WAY):0]         suggested_way_count,
    output logic                             epoch_done,
    output logic                             busy,
    output logic                             epoch_overrun
);

    localparam int IW = $clog2(NUM_WAY);
    localparam int KW = IW + 1;
    localparam int CW = COUNTER_WIDTH;
    localparam int TW = CW + IW;
    localparam int AW = EPOCH_POWER + 1;
    localparam int XW = TW + COVER_SHIFT + 1;

    localparam logic [AW-1:0] ACC_LAST = {1'b0, {EPOCH_POWER{1'b1}}};
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_WAY - 1);
    localparam logic [KW-1:0] K_MIN    = KW'(MIN_WAYS);
    localparam logic [KW-1:0] K_ALL    = KW'(NUM_WAY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_PUBLISH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          sampled;
    logic          epoch_end;
    logic          take_k;
    logic          step;
    logic          hit_test;
    logic          overrun_q;
    logic          unused_addr;

    logic [CW-1:0] live_cnt [NUM_WAY];
    logic [CW-1:0] live_nxt [NUM_WAY];
    logic [CW-1:0] snap     [NUM_WAY];

    logic [TW-1:0] live_total;
    logic [TW-1:0] total_nxt;
    logic [TW-1:0] snap_total;
    logic [TW-1:0] cum;
    logic [TW-1:0] cum_n;
    logic [AW-1:0] acc_cnt;
    logic [IW-1:0] idx;
    logic [KW-1:0] idx_inc;
    logic [KW-1:0] k_new;
    logic [KW-1:0] k_reg;
    logic [XW-1:0] cover_lhs;
    logic [XW-1:0] cover_rhs;

    logic [NUM_WAY-1:0] mask_reg;

    function automatic logic [NUM_WAY-1:0] low_mask(input logic [KW-1:0] n);
        logic [NUM_WAY-1:0] m;
        for (int i = 0; i < NUM_WAY; i++) begin
            m[i] = (KW'(i) < n);
        end
        return m;
    endfunction

    // Only the low SAMPLE_SHIFT address bits choose the sampled sets.
    assign unused_addr = ^set_address;

    generate
        if (SAMPLE_SHIFT == 0) begin : g_all_sets
            assign sampled = access_valid;
        end else begin : g_sub_sets
            assign sampled = access_valid &&
                             (set_address[SAMPLE_SHIFT-1:0] == '0);
        end
    endgenerate

    assign epoch_end = sampled && (acc_cnt == ACC_LAST);

    always_comb begin
        for (int i = 0; i < NUM_WAY; i++) begin
            live_nxt[i] = live_cnt[i];
            if (hit_vec[i] && (live_cnt[i] != '1)) begin
                live_nxt[i] = live_cnt[i] + CW'(1);
            end
        end
        total_nxt = live_total;
        if ((|hit_vec) && (live_total != '1)) begin
            total_nxt = live_total + TW'(1);
        end
    end

    always_ff @(posedge clk_in or posedge reset_with_request_limit) begin
        if (reset_with_request_limit) begin
            for (int i = 0; i < NUM_WAY; i++) begin
                live_cnt[i] <= '0;
            end
            live_total <= '0;
            acc_cnt    <= '0;
        end else if (sampled) begin
            if (epoch_end) begin
                for (int i = 0; i < NUM_WAY; i++) begin
                    live_cnt[i] <= '0;
                end
                live_total <= '0;
                acc_cnt    <= '0;
            end else begin
                for (int i = 0; i < NUM_WAY; i++) begin
                    live_cnt[i] <= live_nxt[i];
                end
                live_total <= total_nxt;
                acc_cnt    <= acc_cnt + AW'(1);
            end
        end
    end

    // A busy scan keeps its snapshot; the late epoch is only flagged.
    always_ff @(posedge clk_in or posedge reset_with_request_limit) begin
        if (reset_with_request_limit) begin
            for (int i = 0; i < NUM_WAY; i++) begin
                snap[i] <= '0;
            end
            snap_total <= '0;
            overrun_q  <= 1'b0;
        end else if (epoch_end) begin
            if (state == S_IDLE) begin
                for (int i = 0; i < NUM_WAY; i++) begin
                    snap[i] <= live_nxt[i];
                end
                snap_total <= total_nxt;
            end else begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_comb begin
        cum_n     = cum + TW'(snap[idx]);
        cover_lhs = XW'(cum_n) << COVER_SHIFT;
        cover_rhs = XW'(snap_total) * XW'(COVER_NUM);
        hit_test  = (cover_lhs >= cover_rhs);
        idx_inc   = KW'(idx) + KW'(1);
        k_new     = (idx_inc < K_MIN) ? K_MIN : idx_inc;
    end

    always_ff @(posedge clk_in or posedge reset_with_request_limit) begin
        if (reset_with_request_limit) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        take_k     = 1'b0;
        step       = 1'b0;
        epoch_done = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (epoch_end) begin
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (snap_total == '0) begin
                    state_nxt = S_PUBLISH;
                end else if (hit_test || (idx == IDX_LAST)) begin
                    take_k    = 1'b1;
                    state_nxt = S_PUBLISH;
                end else begin
                    step = 1'b1;
                end
            end
            S_PUBLISH: begin
                epoch_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_with_request_limit) begin
        if (reset_with_request_limit) begin
            idx      <= '0;
            cum      <= '0;
            k_reg    <= K_ALL;
            mask_reg <= '1;
        end else begin
            if ((state == S_IDLE) && epoch_end) begin
                idx <= '0;
                cum <= '0;
            end else if (step) begin
                idx <= idx + IW'(1);
                cum <= cum_n;
            end
            if (take_k) begin
                k_reg    <= k_new;
                mask_reg <= low_mask(k_new);
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_WAY; g++) begin : g_flat
            assign cat_counter_flatted[g*CW +: CW] = snap[g];
        end
    endgenerate

    assign busy                = (state != S_IDLE);
    assign epoch_overrun       = overrun_q;
    assign suggested_waymask   = cfg_enable ? mask_reg : '1;
    assign suggested_way_count = cfg_enable ? k_reg : K_ALL;

endmodule
